// File: rtl/proj_sweep_counter_if.sv
// Control, configuration and index-stream signals of the sweep index generator.
// The sequencer/consumer side uses master; the counter uses slave.
interface proj_sweep_counter_if #(
    parameter int IDX_W  = 8,
    parameter int STEP_W = 4,
    parameter int PASS_W = 4
);
    logic              start;
    logic              abort;
    logic [IDX_W-1:0]  cfg_limit;
    logic [STEP_W-1:0] cfg_step;
    logic              cfg_repeat;
    logic [PASS_W-1:0] cfg_passes;
    logic              index_stall;
    logic [IDX_W-1:0]  index;
    logic              index_valid;
    logic [PASS_W-1:0] pass_idx;
    logic              busy;
    logic              finished_count;
    logic              err_cfg;

    modport master (
        output start, abort, cfg_limit, cfg_step, cfg_repeat, cfg_passes, index_stall,
        input  index, index_valid, pass_idx, busy, finished_count, err_cfg
    );

    modport slave (
        input  start, abort, cfg_limit, cfg_step, cfg_repeat, cfg_passes, index_stall,
        output index, index_valid, pass_idx, busy, finished_count, err_cfg
    );
endinterface

// File: rtl/proj_sweep_counter.sv
// Programmable multi-pass index sweep generator with stall handshake and abort.
// A start rising edge latches the configuration; indices step by the stride up to the inclusive limit.
module proj_sweep_counter #(
    parameter int IDX_W  = 8,
    parameter int STEP_W = 4,
    parameter int PASS_W = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    proj_sweep_counter_if.slave   sw
);

    localparam int SUM_W = ((IDX_W > STEP_W) ? IDX_W : STEP_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [IDX_W-1:0]  limit_q, limit_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              repeat_q, repeat_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              start_prev_q;
    logic              err_q, err_d;
    logic              rise;
    logic [SUM_W-1:0]  nxt;
    logic              pass_end;

    // Sum is one bit wider than either operand so a stride past the top cannot wrap back under the limit.
    function automatic logic [SUM_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                    input logic [STEP_W-1:0] step);
        return SUM_W'(idx) + SUM_W'(step);
    endfunction

    // A programmed pass count of zero behaves as a single pass.
    function automatic logic [PASS_W-1:0] last_pass(input logic [PASS_W-1:0] passes);
        return (passes == '0) ? '0 : passes - PASS_W'(1);
    endfunction

    assign rise     = sw.start & ~start_prev_q;
    assign nxt      = next_index(index_q, step_q);
    assign pass_end = (nxt > SUM_W'(limit_q));

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        pass_d   = pass_q;
        limit_d  = limit_q;
        step_d   = step_q;
        repeat_d = repeat_q;
        passes_d = passes_q;
        err_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (sw.abort) begin
                    state_d = ST_IDLE;
                    index_d = '0;
                    pass_d  = '0;
                end else if (!sw.index_stall) begin
                    if (!pass_end) begin
                        index_d = nxt[IDX_W-1:0];
                    end else if (repeat_q && (pass_q < last_pass(passes_q))) begin
                        index_d = '0;
                        pass_d  = pass_q + PASS_W'(1);
                    end else begin
                        state_d = ST_DONE;
                        index_d = '0;
                        pass_d  = '0;
                    end
                end
            end
            default: begin
                // IDLE and the single DONE cycle both accept a new launch.
                state_d = ST_IDLE;
                if (rise && !sw.abort) begin
                    if (sw.cfg_step != '0) begin
                        state_d  = ST_RUN;
                        index_d  = '0;
                        pass_d   = '0;
                        limit_d  = sw.cfg_limit;
                        step_d   = sw.cfg_step;
                        repeat_d = sw.cfg_repeat;
                        passes_d = sw.cfg_passes;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            pass_q       <= '0;
            limit_q      <= '0;
            step_q       <= '0;
            repeat_q     <= 1'b0;
            passes_q     <= '0;
            start_prev_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            pass_q       <= pass_d;
            limit_q      <= limit_d;
            step_q       <= step_d;
            repeat_q     <= repeat_d;
            passes_q     <= passes_d;
            start_prev_q <= sw.start;
            err_q        <= err_d;
        end
    end

    assign sw.index          = index_q;
    assign sw.pass_idx       = pass_q;
    assign sw.index_valid    = (state_q == ST_RUN);
    assign sw.busy           = (state_q == ST_RUN);
    assign sw.finished_count = (state_q == ST_DONE);
    assign sw.err_cfg        = err_q;

endmodule

// File: tb/tb_proj_sweep_counter.sv
// Directed bench for proj_sweep_counter: an 8-bit and a 4-bit instance, expected index streams
// queued by a sweep model and popped as the DUT presents indices.
module tb_proj_sweep_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proj_sweep_counter_if #(.IDX_W(8), .STEP_W(4), .PASS_W(4)) if8 ();
    proj_sweep_counter_if #(.IDX_W(4), .STEP_W(4), .PASS_W(4)) if4 ();

    proj_sweep_counter #(.IDX_W(8), .STEP_W(4), .PASS_W(4)) dut8 (
        .in_clk(clk), .in_rst(rst), .sw(if8.slave));
    proj_sweep_counter #(.IDX_W(4), .STEP_W(4), .PASS_W(4)) dut4 (
        .in_clk(clk), .in_rst(rst), .sw(if4.slave));

    int compared = 0;
    int mismatched = 0;

    typedef struct { int idx; int pas; } exp_t;
    exp_t q_exp[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] o_idx(input bit s);
        return s ? 32'(if4.index) : 32'(if8.index);
    endfunction
    function automatic logic [31:0] o_pass(input bit s);
        return s ? 32'(if4.pass_idx) : 32'(if8.pass_idx);
    endfunction
    function automatic logic [31:0] o_valid(input bit s);
        return s ? 32'(if4.index_valid) : 32'(if8.index_valid);
    endfunction
    function automatic logic [31:0] o_busy(input bit s);
        return s ? 32'(if4.busy) : 32'(if8.busy);
    endfunction
    function automatic logic [31:0] o_fin(input bit s);
        return s ? 32'(if4.finished_count) : 32'(if8.finished_count);
    endfunction
    function automatic logic [31:0] o_err(input bit s);
        return s ? 32'(if4.err_cfg) : 32'(if8.err_cfg);
    endfunction

    task automatic set_cfg(input bit s, input int lim, input int stp, input bit rep, input int pas);
        if (s) begin
            if4.cfg_limit = 4'(lim); if4.cfg_step = 4'(stp);
            if4.cfg_repeat = rep;    if4.cfg_passes = 4'(pas);
        end else begin
            if8.cfg_limit = 8'(lim); if8.cfg_step = 4'(stp);
            if8.cfg_repeat = rep;    if8.cfg_passes = 4'(pas);
        end
    endtask

    task automatic set_start(input bit s, input bit v);
        if (s) if4.start = v; else if8.start = v;
    endtask

    task automatic set_stall(input bit s, input bit v);
        if (s) if4.index_stall = v; else if8.index_stall = v;
    endtask

    task automatic check_idle(input bit s, input string tag);
        check({tag, ".busy"},  o_busy(s),  0);
        check({tag, ".valid"}, o_valid(s), 0);
        check({tag, ".index"}, o_idx(s),   0);
        check({tag, ".pass"},  o_pass(s),  0);
        check({tag, ".fin"},   o_fin(s),   0);
        check({tag, ".err"},   o_err(s),   0);
    endtask

    // Launch a sweep, compare every presented index against the model stream, then the DONE cycle.
    task automatic sweep(input bit s, input int lim, input int stp, input bit rep, input int pas,
                         input int stall_idx, input int stall_n, input string tag);
        int n_pass, cycles, stall_left, expect_cycles;
        q_exp.delete();
        n_pass = rep ? ((pas == 0) ? 1 : pas) : 1;
        for (int p = 0; p < n_pass; p++)
            for (int v = 0; v <= lim; v += stp)
                q_exp.push_back('{v, p});
        expect_cycles = q_exp.size() + stall_n;
        set_cfg(s, lim, stp, rep, pas);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        cycles = 0;
        stall_left = stall_n;
        while (q_exp.size() > 0 && cycles < 300) begin
            check($sformatf("%s.valid[%0d]", tag, cycles), o_valid(s), 1);
            check($sformatf("%s.index[%0d]", tag, cycles), o_idx(s), 32'(q_exp[0].idx));
            check($sformatf("%s.pass[%0d]", tag, cycles), o_pass(s), 32'(q_exp[0].pas));
            check($sformatf("%s.fin[%0d]", tag, cycles), o_fin(s), 0);
            cycles++;
            if (stall_left > 0 && q_exp[0].idx == stall_idx) begin
                set_stall(s, 1'b1);
                stall_left--;
            end else begin
                set_stall(s, 1'b0);
                void'(q_exp.pop_front());
            end
            @(negedge clk);
        end
        set_stall(s, 1'b0);
        check({tag, ".cycles"}, 32'(cycles), 32'(expect_cycles));
        check({tag, ".done_fin"},   o_fin(s),   1);
        check({tag, ".done_busy"},  o_busy(s),  0);
        check({tag, ".done_valid"}, o_valid(s), 0);
        check({tag, ".done_index"}, o_idx(s),   0);
        @(negedge clk);
        check({tag, ".after_fin"},  o_fin(s),   0);
        check({tag, ".after_busy"}, o_busy(s),  0);
    endtask

    initial begin
        int found, nvalid, nfin;
        if8.start = 1'b0; if8.abort = 1'b0; if8.index_stall = 1'b0;
        if4.start = 1'b0; if4.abort = 1'b0; if4.index_stall = 1'b0;
        set_cfg(0, 0, 0, 1'b0, 0);
        set_cfg(1, 0, 0, 1'b0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle(0, "reset8");
        check_idle(1, "reset4");
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "post_reset8");

        sweep(0, 5, 2, 1'b0, 0, -1, 0, "basic");
        sweep(0, 3, 1, 1'b1, 2, -1, 0, "multi2");
        sweep(0, 3, 1, 1'b1, 0, -1, 0, "multi0");
        sweep(1, 15, 3, 1'b0, 0, -1, 0, "ovf_s3");
        sweep(1, 15, 4, 1'b0, 0, -1, 0, "ovf_s4");
        sweep(0, 0, 1, 1'b0, 0, -1, 0, "limit0");
        sweep(0, 3, 1, 1'b0, 0, 1, 3, "stall");

        // Abort mid-sweep.
        set_cfg(0, 5, 1, 1'b0, 0);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (if8.index_valid === 1'b1 && if8.index === 8'd2) found = 1;
            else @(negedge clk);
        end
        check("abort.reach", 32'(found), 1);
        if8.abort = 1'b1;
        @(negedge clk);
        if8.abort = 1'b0;
        check_idle(0, "abort");
        @(negedge clk);
        check_idle(0, "abort_next");

        // Abort in IDLE suppresses a same-cycle start.
        set_cfg(0, 3, 1, 1'b0, 0);
        if8.start = 1'b1; if8.abort = 1'b1;
        @(negedge clk);
        if8.abort = 1'b0;
        check_idle(0, "abort_start");
        @(negedge clk);
        check("abort_start.held_busy", o_busy(0), 0);
        if8.start = 1'b0;
        @(negedge clk);

        // Zero stride is rejected with a single error pulse.
        set_cfg(0, 3, 0, 1'b0, 0);
        if8.start = 1'b1;
        @(negedge clk);
        check("errcfg.pulse", o_err(0),  1);
        check("errcfg.busy",  o_busy(0), 0);
        @(negedge clk);
        check("errcfg.clear", o_err(0),  0);
        check("errcfg.busy2", o_busy(0), 0);
        if8.start = 1'b0;
        @(negedge clk);

        // Holding start high launches exactly one sweep.
        set_cfg(0, 3, 1, 1'b0, 0);
        if8.start = 1'b1;
        nvalid = 0; nfin = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (if8.index_valid === 1'b1) nvalid++;
            if (if8.finished_count === 1'b1) nfin++;
            if (i == 19) if8.start = 1'b0;
        end
        check("held.valid_cycles", 32'(nvalid), 4);
        check("held.fin_pulses",   32'(nfin),   1);

        // Asynchronous reset between edges while index is 4.
        set_cfg(0, 9, 1, 1'b0, 0);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (if8.index_valid === 1'b1 && if8.index === 8'd4) found = 1;
            else @(negedge clk);
        end
        check("rst_mid.reach", 32'(found), 1);
        #2 rst = 1'b1;
        #1;
        check_idle(0, "rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_mid.quiet_busy[%0d]", i),  o_busy(0),  0);
            check($sformatf("rst_mid.quiet_valid[%0d]", i), o_valid(0), 0);
        end
        sweep(0, 5, 1, 1'b0, 0, -1, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
